// File: rtl/axis_core_credit_wrapper_if.sv
// ---------------------------------------------------------------------------
// axis_core_credit_wrapper_if
//   Minimal AXI-Stream bundle (tvalid/tready/tdata/tstrb/tlast) used for both
//   the slave and the master side of axis_core_credit_wrapper.
//   Parameters:
//     DATA_W  tdata width; tstrb is DATA_W/8 bits
//   Modports:
//     master  drives tvalid/tdata/tstrb/tlast, samples tready
//     slave   samples tvalid/tdata/tstrb/tlast, drives tready
// ---------------------------------------------------------------------------
interface axis_core_credit_wrapper_if #(
  parameter int DATA_W = 128
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_core_credit_wrapper.sv
// ---------------------------------------------------------------------------
// axis_core_credit_wrapper
//   AXI-Stream shell around a fixed-latency, lane-parallel compute core.
//   Each accepted slave beat is fanned out to the core as per-lane valids.
//   A LATENCY-deep tag pipe carries {valid, last} alongside the core, and the
//   tag (not the core's own valid) writes the core result into a show-ahead
//   output FIFO. Back-pressure is an exact credit count: FIFO occupancy plus
//   beats still inside the core must stay below DEPTH, so the FIFO cannot
//   overflow regardless of how long the master stalls.
//
//   Ports:
//     clk, rst      single clock; asynchronous active-high reset
//     s_axis        slave stream (tstrb[NUM_LANE-1:0] are lane valids)
//     m_axis        master stream (tdata = zero-extended core result)
//     core_i_data   lane data to core (low NUM_LANE*LANE_W bits of tdata)
//     core_i_valid  per-lane valids, only during an accepted beat
//     core_i_last   tlast of the accepted beat
//     core_o_data   core result
//     core_o_valid  core result valid; cross-checked against the tag pipe
//     pkt_cnt       packets popped on the master side (wraps at 2^16)
//     err_sync      sticky flag: core_o_valid disagreed with the tag pipe
// ---------------------------------------------------------------------------
module axis_core_credit_wrapper #(
  parameter int S_DATA_W   = 128,
  parameter int M_DATA_W   = 256,
  parameter int NUM_LANE   = 8,
  parameter int LANE_W     = 9,
  parameter int CORE_OUT_W = 200,
  parameter int LATENCY    = 18,
  parameter int DEPTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_core_credit_wrapper_if.slave     s_axis,
  axis_core_credit_wrapper_if.master    m_axis,
  output logic [NUM_LANE*LANE_W-1:0]    core_i_data,
  output logic [NUM_LANE-1:0]           core_i_valid,
  output logic                          core_i_last,
  input  logic [CORE_OUT_W-1:0]         core_o_data,
  input  logic                          core_o_valid,
  output logic [15:0]                   pkt_cnt,
  output logic                          err_sync
);

  localparam int IN_W  = NUM_LANE * LANE_W;
  localparam int AW    = $clog2(DEPTH);
  // Counts must hold the value DEPTH itself (full FIFO).
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = M_DATA_W + 1;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic                 run_q;          // low in reset and until the first edge after release
  logic [LATENCY-1:0]   tag_v;
  logic [LATENCY-1:0]   tag_last;
  logic [CNT_W-1:0]     inflight_cnt;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [ENT_W-1:0]     mem [DEPTH];

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic                 tready_int;
  logic                 accept;
  logic                 pop;
  logic                 tag_out_v;
  logic                 tag_out_last;
  logic [CNT_W:0]       credit_used;
  logic [M_DATA_W-1:0]  core_ext;
  logic [ENT_W-1:0]     head;
  logic                 out_valid;
  logic                 unused_in_bits;

  // Credit check uses registered counts only, so tready never depends
  // combinationally on tvalid. A pop frees its credit one cycle later.
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
  assign tready_int  = run_q & (credit_used < (CNT_W + 1)'(DEPTH));

  assign accept = s_axis.tvalid & tready_int;
  assign s_axis.tready = tready_int;

  // -------------------------------------------------------------------------
  // Core fan-out
  // -------------------------------------------------------------------------
  assign core_i_data  = s_axis.tdata[IN_W-1:0];
  assign core_i_valid = s_axis.tstrb[NUM_LANE-1:0] & {NUM_LANE{accept}};
  assign core_i_last  = s_axis.tlast & accept;

  // Upper tdata bits and unused strobes are ignored by design.
  assign unused_in_bits = ^{s_axis.tdata, s_axis.tstrb};

  // Zero-extend the core result into the master data width; written as a
  // default-then-overlay so it also works when the widths are equal.
  always_comb begin
    core_ext = '0;
    core_ext[CORE_OUT_W-1:0] = core_o_data;
  end

  // -------------------------------------------------------------------------
  // Start-up gate: keeps tready low while in reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipe: shadows the core latency, advanced every cycle
  // (independent of master back-pressure because the core cannot stall).
  // -------------------------------------------------------------------------
  assign tag_out_v    = tag_v[LATENCY-1];
  assign tag_out_last = tag_last[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v    <= '0;
      tag_last <= '0;
    end else begin
      tag_v[0]    <= accept;
      tag_last[0] <= s_axis.tlast & accept;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Sticky disagreement flag between the core's own valid and the tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sync <= 1'b0;
    end else if (tag_out_v != core_o_valid) begin
      err_sync <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // In-flight count: beats accepted but not yet written to the FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_cnt <= '0;
    end else begin
      case ({accept, tag_out_v})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO (show-ahead). The tag is the write strobe, so a misbehaving
  // core valid never changes the number of output beats.
  // -------------------------------------------------------------------------
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & m_axis.tready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (tag_out_v) begin
      mem[wr_ptr] <= {tag_out_last, core_ext};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (tag_out_v) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({tag_out_v, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Master outputs are gated so nothing stale is visible while empty.
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? head[M_DATA_W-1:0] : '0;
  assign m_axis.tstrb  = {(M_DATA_W/8){out_valid}};
  assign m_axis.tlast  = out_valid & head[M_DATA_W];

  // -------------------------------------------------------------------------
  // Packet counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pop && head[M_DATA_W]) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule
